// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operand width,
// md_op codes and the controller state encoding.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on operand
// magnitudes, one step per cycle, with the sign fix-up applied to the final step.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc_hi is partial product / remainder, acc_lo is multiplier / quotient
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_q, neg_r, div0;

    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod;

    assign s1_neg = md_is_signed(op) & src1[WIDTH-1];
    assign s2_neg = md_is_signed(op) & src2[WIDTH-1];
    assign mag1   = s1_neg ? -src1 : src1;
    assign mag2   = s2_neg ? -src2 : src2;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_hi = mul_sum[WIDTH:1];
        nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    assign prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            // A zero divisor yields an all-ones quotient and |dividend| as remainder,
            // so the remainder sign fix-up alone restores the original dividend.
            res_hi = neg_r ? -nxt_hi : nxt_hi;
            res_lo = div0 ? '1 : (neg_q ? -nxt_lo : nxt_lo);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= mag1;
            opnd   <= mag2;
            is_div <= md_is_div(op);
            neg_q  <= s1_neg ^ s2_neg;
            neg_r  <= md_is_div(op) & s1_neg;
            div0   <= md_is_div(op) & (src2 == '0);
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/DIV controller: IDLE/RUN FSM, iteration counter, EX stall and the
// architectural HI/LO registers fed by muldiv_core.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_src1,
    input  logic [WIDTH-1:0] md_src2,
    input  logic             hilo_wr,
    input  logic             hilo_rd,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    input  logic             flush,
    output logic             stall_E,
    output logic             busy,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    md_state_e        state, state_nxt;
    logic [CW-1:0]    count;
    logic             running, last, accept, complete;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign running  = (state == ST_RUN);
    assign last     = (count == CW'(1));
    assign accept   = !running && md_start && !flush;
    assign complete = running && last && !flush;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (flush || last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                count <= CW'(ITER);
            else if (running)
                count <= flush ? '0 : count - 1'b1;
        end
    end

    // md_start outranks a same-cycle MTHI/MTLO; a stalled MTHI/MTLO never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (complete) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (!running && hilo_wr && !md_start) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (running),
        .op     (md_op_e'(md_op)),
        .src1   (md_src1),
        .src2   (md_src2),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Outputs are forced quiet while reset is held, before the registers have cleared.
    assign busy       = running && !reset;
    assign stall_E    = busy && (md_start || hilo_rd || hilo_wr);
    assign hilo_rdata = reset ? '0 : (hilo_sel ? hi : lo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of MULT/DIV vectors plus hand-written
// sequences for stall, flush, MTHI/MTLO interaction and mid-op reset.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, md_start, hilo_wr, hilo_rd, hilo_sel, flush;
    logic [1:0]  md_op;
    logic [31:0] md_src1, md_src2, hilo_wdata;
    logic        stall_E, busy;
    logic [31:0] hilo_rdata, hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_src1    (md_src1),
        .md_src2    (md_src2),
        .hilo_wr    (hilo_wr),
        .hilo_rd    (hilo_rd),
        .hilo_sel   (hilo_sel),
        .hilo_wdata (hilo_wdata),
        .flush      (flush),
        .stall_E    (stall_E),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and count busy cycles until it finishes (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        md_op    = op;
        md_src1  = a;
        md_src2  = b;
        md_start = 1'b1;
        #1;
        check("accept_no_stall", 64'(stall_E), 64'(0));
        tick();
        md_start = 1'b0;
        cycles   = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[7] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9] = '{2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};

        reset = 1'b1; md_start = 1'b1; md_op = 2'b01; md_src1 = 32'd2; md_src2 = 32'd3;
        hilo_wr = 1'b0; hilo_rd = 1'b1; hilo_sel = 1'b0; hilo_wdata = '0; flush = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_stall", 64'(stall_E), 64'(0));
        check("reset_rdata", 64'(hilo_rdata), 64'(0));
        tick();
        tick();
        md_start = 1'b0; hilo_rd = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_hi", 64'(hi), 64'(0));
        check("post_reset_lo", 64'(lo), 64'(0));

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(32));
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end

        // DIVU 100/7 with MFLO issued in the first RUN cycle.
        md_op = 2'b11; md_src1 = 32'd100; md_src2 = 32'd7; md_start = 1'b1;
        tick();
        md_start = 1'b0; hilo_rd = 1'b1; hilo_sel = 1'b0;
        #1;
        n = 0;
        while (stall_E && n < 100) begin
            n++;
            tick();
        end
        check("mflo_stall_cycles", 64'(n), 64'(32));
        check("mflo_rdata", 64'(hilo_rdata), 64'(14));
        hilo_sel = 1'b1;
        #1;
        check("mfhi_rdata", 64'(hilo_rdata), 64'(2));
        hilo_rd = 1'b0;

        // MTHI in IDLE, then MULTU flushed at RUN cycle 10.
        tick();
        hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hA5A5_A5A5;
        #1;
        check("mthi_idle_stall", 64'(stall_E), 64'(0));
        tick();
        hilo_wr = 1'b0;
        check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        md_op = 2'b01; md_src1 = 32'd2; md_src2 = 32'd3; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (9) tick();
        check("flush_busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'(0));
        check("flush_hi", 64'(hi), 64'hA5A5_A5A5);
        check("flush_lo", 64'(lo), 64'(14));
        repeat (30) tick();
        check("flush_hi_later", 64'(hi), 64'hA5A5_A5A5);

        // flush with md_start in IDLE: not accepted.
        md_start = 1'b1; flush = 1'b1;
        tick();
        md_start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 64'(busy), 64'(0));

        // md_start wins over a same-cycle MTHI.
        md_op = 2'b01; md_src1 = 32'd2; md_src2 = 32'd3; md_start = 1'b1;
        hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h0000_DEAD;
        tick();
        md_start = 1'b0; hilo_wr = 1'b0;
        check("start_wins_busy", 64'(busy), 64'(1));
        check("start_wins_hi", 64'(hi), 64'hA5A5_A5A5);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("start_wins_lo", 64'(lo), 64'(6));

        // Back-to-back MULTU then a stalled MTLO.
        md_op = 2'b01; md_src1 = 32'h0001_0000; md_src2 = 32'h0003_0000; md_start = 1'b1;
        tick();
        md_start = 1'b0; hilo_wr = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h55;
        #1;
        n = 0;
        while (stall_E && n < 100) begin
            check("mtlo_blocked", 64'(lo), 64'(6));
            n++;
            tick();
        end
        check("mtlo_stall_cycles", 64'(n), 64'(32));
        tick();
        hilo_wr = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h55);
        check("mtlo_hi", 64'(hi), 64'(3));

        // Reset in the middle of a MULTU.
        md_op = 2'b01; md_src1 = 32'd5; md_src2 = 32'd7; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (5) tick();
        hilo_sel = 1'b0;
        reset = 1'b1; flush = 1'b1;
        #1;
        check("rst_run_busy", 64'(busy), 64'(0));
        check("rst_run_rdata", 64'(hilo_rdata), 64'(0));
        tick();
        reset = 1'b0; flush = 1'b0;
        check("rst_run_hi", 64'(hi), 64'(0));
        check("rst_run_lo", 64'(lo), 64'(0));
        repeat (40) tick();
        check("rst_run_lo_later", 64'(lo), 64'(0));
        check("rst_run_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
